digit_cell_renderer: RTL and testbench
======================================

Name: digit_cell_renderer

Overview:
- Consumes the 5-bit row codes produced by the per-digit glyph ROMs (num_0..num_9, 8 rows x 5 columns each).
- Sits between the VGA sync generator and the RGB output mux.
- Maps the current pixel coordinate to a glyph row and column, drives the row/digit select to the ROM bank, and registers the selected bit as a colour pixel.
- Latches a new digit value without tearing, committing it only at frame start.

Parameters:
- X0, 10'd320, left edge of the digit box (screen pixels).
- Y0, 10'd240, top edge of the digit box.
- SCALE_LOG2, 3, each glyph pixel spans 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels; legal range 0..4.
- FG, 8'hFF, RGB332 colour for glyph "1" bits.
- BG, 8'h00, RGB332 colour for glyph "0" bits and for pixels outside the box.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- pix_x  in  10  current pixel column from the sync generator.
- pix_y  in  10  current pixel row.
- video_on  in  1  high in the active display area.
- hsync_in  in  1  raw hsync, active low.
- vsync_in  in  1  raw vsync, active low.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- digit_in  in  4  digit to display; 0..9 valid, 10..15 mean blank.
- digit_load  in  1  one-cycle strobe that captures digit_in.
- blink  in  1  blink request (used only with DIGIT_BLINK_EN).
- row_sel  out  3  glyph row index sent to the ROM bank (in_row).
- digit_sel  out  4  digit currently shown; selects which ROM drives glyph_code.
- glyph_code  in  5  ROM out_code, combinational from row_sel/digit_sel; bit4 = leftmost column.
- rgb_out  out  8  pixel colour.
- hsync_out  out  1  hsync delayed to align with rgb_out.
- vsync_out  out  1  vsync delayed to align with rgb_out.
- pending  out  1  high while a loaded digit waits for frame_start.

Behaviour:
- Box geometry: W = 5<<SCALE_LOG2, H = 8<<SCALE_LOG2.
- in_box = video_on & (X0 <= pix_x < X0+W) & (Y0 <= pix_y < Y0+H).
- Compare in 11-bit arithmetic so X0+W cannot overflow.
- Stage 1 registers, updated every cycle:
  - row_sel = (pix_y-Y0)>>SCALE_LOG2 [2:0].
  - col_r = (pix_x-X0)>>SCALE_LOG2, range 0..4.
  - in_box_r, video_on_r, hsync_r1, vsync_r1.
  - When not in_box, row_sel and col_r hold 0.
- ROM return: glyph_code is valid in the same cycle as the stage-1 registers.
- Stage 2 registers:
  - bit = glyph_code[4-col_r].
  - rgb_out = (in_box_r & bit & digit_sel<=9) ? FG : (video_on_r ? BG : 8'h00).
  - hsync_out/vsync_out come from hsync_r1/vsync_r1.
- Latency: rgb_out, hsync_out and vsync_out are exactly 2 cycles after the pix_x/pix_y/sync inputs.
- Rows 6 and 7 come from ROM defaults (zero) and render BG. No special casing.
- Digit latch:
  - digit_load writes digit_in to pend_r and sets pending=1.
  - A second load while pending overwrites pend_r; pending stays 1.
  - frame_start with pending=1: digit_sel <= pend_r, pending <= 0.
  - frame_start with digit_load in the same cycle: digit_sel <= digit_in directly, pending <= 0.
  - frame_start with pending=0 and no load: digit_sel unchanged.
  - digit_sel therefore changes only on a frame_start cycle, never mid-frame.
- Digits 10..15 are accepted and stored; they render as all BG. row_sel still toggles for them.
- Reset (synchronous):
  - rgb_out = 8'h00, hsync_out = vsync_out = 1, hsync_r1 = vsync_r1 = 1.
  - row_sel = 0, col_r = 0, in_box_r = 0, video_on_r = 0.
  - digit_sel = 4'hF (blank), pend_r = 0, pending = 0.
- Reset mid-frame discards any pending digit. Output stays blank until a load followed by a frame_start.

Optional Feature:
DIGIT_BLINK_EN
- Defined:
  - 5-bit frame counter increments on every frame_start; reset value 0; wraps 31 to 0.
  - When blink=1 and counter[4]=1, glyph bits are forced to 0 (box renders BG). Period is 32 frames.
  - Blanking takes effect at stage 2 with no added latency.
- Undefined: no counter is built, the blink input is ignored, and rendering is identical to blink=0.

Test Plan:
- Reset, then digit_load with 6 followed by frame_start → pending goes 1 then 0; digit_sel = 6.
- Scan row pix_y = Y0 (SCALE_LOG2 = 3), pix_x X0..X0+39 → rgb_out shows pattern 01110 as BG x8, FG x24, BG x8, two cycles after each input.
- Pixel at (X0-1, Y0) and (X0+40, Y0) → BG; video_on = 0 → 8'h00; hsync_in pulse → hsync_out identical pulse 2 cycles later.
- digit_load 3 then digit_load 8 mid-frame → digit_sel stays 6 until frame_start, then becomes 8.
- digit_load 12 with frame_start in the same cycle → digit_sel = 12 in the next cycle; whole box BG; pending = 0.
- With DIGIT_BLINK_EN and blink = 1: frames 0..15 show the glyph and frames 16..31 show BG. Without the macro, all frames show the glyph.

Source files
------------

// File: rtl/digit_cell_renderer.sv
// Renders one glyph-ROM digit into a scaled screen box, 2-cycle pixel/sync latency.
// Optional DIGIT_BLINK_EN macro adds a 32-frame blink counter.
module digit_cell_renderer #(
  parameter logic [9:0]  X0         = 10'd320,
  parameter logic [9:0]  Y0         = 10'd240,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter logic [7:0]  FG         = 8'hFF,
  parameter logic [7:0]  BG         = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       frame_start,
  input  logic [3:0] digit_in,
  input  logic       digit_load,
  input  logic       blink,
  output logic [2:0] row_sel,
  output logic [3:0] digit_sel,
  input  logic [4:0] glyph_code,
  output logic [7:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       pending
);

  localparam logic [10:0] BOX_W = 11'(5 << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(8 << SCALE_LOG2);
  localparam logic [10:0] X_LO  = {1'b0, X0};
  localparam logic [10:0] Y_LO  = {1'b0, Y0};
  localparam logic [10:0] X_HI  = X_LO + BOX_W;
  localparam logic [10:0] Y_HI  = Y_LO + BOX_H;

  logic [10:0] x_ext, y_ext, dx, dy;
  logic        in_box, glyph_bit, blank;

  logic [2:0] row_sel_d, row_sel_q;
  logic [2:0] col_d, col_q;
  logic       in_box_d, in_box_q;
  logic       video_on_d, video_on_q;
  logic       hsync_r1_d, hsync_r1_q;
  logic       vsync_r1_d, vsync_r1_q;
  logic [7:0] rgb_d, rgb_q;
  logic       hsync_out_d, hsync_out_q;
  logic       vsync_out_d, vsync_out_q;
  logic [3:0] digit_sel_d, digit_sel_q;
  logic [3:0] pend_d, pend_q;
  logic       pending_d, pending_q;

  // 11-bit compares so X0+W / Y0+H never wrap
  assign x_ext  = {1'b0, pix_x};
  assign y_ext  = {1'b0, pix_y};
  assign dx     = x_ext - X_LO;
  assign dy     = y_ext - Y_LO;
  assign in_box = video_on & (x_ext >= X_LO) & (x_ext < X_HI)
                           & (y_ext >= Y_LO) & (y_ext < Y_HI);

`ifdef DIGIT_BLINK_EN
  logic [4:0] frm_cnt_d, frm_cnt_q;

  assign frm_cnt_d = frame_start ? frm_cnt_q + 5'd1 : frm_cnt_q;
  assign blank     = blink & frm_cnt_q[4];

  always_ff @(posedge clk) begin
    if (reset) frm_cnt_q <= '0;
    else       frm_cnt_q <= frm_cnt_d;
  end
`else
  logic blink_unused;
  assign blink_unused = blink;
  assign blank        = 1'b0;
`endif

  always_comb begin
    row_sel_d   = '0;
    col_d       = '0;
    if (in_box) begin
      row_sel_d = 3'(dy >> SCALE_LOG2);
      col_d     = 3'(dx >> SCALE_LOG2);
    end
    in_box_d    = in_box;
    video_on_d  = video_on;
    hsync_r1_d  = hsync_in;
    vsync_r1_d  = vsync_in;

    // glyph_code bit4 is the leftmost column
    glyph_bit   = glyph_code[3'd4 - col_q] & ~blank;
    rgb_d       = (in_box_q & glyph_bit & (digit_sel_q <= 4'd9)) ? FG :
                  (video_on_q ? BG : 8'h00);
    hsync_out_d = hsync_r1_q;
    vsync_out_d = vsync_r1_q;

    digit_sel_d = digit_sel_q;
    pend_d      = pend_q;
    pending_d   = pending_q;
    if (digit_load) begin
      pend_d    = digit_in;
      pending_d = 1'b1;
    end
    // commit only at frame start so a frame is never torn
    if (frame_start) begin
      if (digit_load)     digit_sel_d = digit_in;
      else if (pending_q) digit_sel_d = pend_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_sel_q   <= '0;
      col_q       <= '0;
      in_box_q    <= 1'b0;
      video_on_q  <= 1'b0;
      hsync_r1_q  <= 1'b1;
      vsync_r1_q  <= 1'b1;
      rgb_q       <= 8'h00;
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
      digit_sel_q <= 4'hF;
      pend_q      <= '0;
      pending_q   <= 1'b0;
    end else begin
      row_sel_q   <= row_sel_d;
      col_q       <= col_d;
      in_box_q    <= in_box_d;
      video_on_q  <= video_on_d;
      hsync_r1_q  <= hsync_r1_d;
      vsync_r1_q  <= vsync_r1_d;
      rgb_q       <= rgb_d;
      hsync_out_q <= hsync_out_d;
      vsync_out_q <= vsync_out_d;
      digit_sel_q <= digit_sel_d;
      pend_q      <= pend_d;
      pending_q   <= pending_d;
    end
  end

  assign row_sel   = row_sel_q;
  assign digit_sel = digit_sel_q;
  assign rgb_out   = rgb_q;
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_digit_cell_renderer.sv
// Bench for digit_cell_renderer: glyph ROM model, table vectors, directed latch
// sequences and randomized pixels against a frame-level reference model.
module tb_digit_cell_renderer;
  localparam logic [7:0] FG_C = 8'hFC;
  localparam logic [7:0] BG_C = 8'h49;

  logic       clk = 1'b0;
  logic       reset, video_on, hsync_in, vsync_in, frame_start, digit_load, blink;
  logic [9:0] pix_x, pix_y;
  logic [3:0] digit_in, digit_sel;
  logic [2:0] row_sel;
  logic [4:0] glyph_code;
  logic [7:0] rgb_out;
  logic       hsync_out, vsync_out, pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_cell_renderer #(.X0(10'd320), .Y0(10'd240), .SCALE_LOG2(3), .FG(FG_C), .BG(BG_C)) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .digit_in(digit_in), .digit_load(digit_load), .blink(blink),
    .row_sel(row_sel), .digit_sel(digit_sel), .glyph_code(glyph_code),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .pending(pending));

  // 6 drawn rows per digit; rows 6/7 read as zero. Blank codes return all-ones
  // so the renderer's own digit<=9 gating is what keeps them dark.
  function automatic logic [4:0] rom_fn(input logic [3:0] d, input logic [2:0] r);
    logic [29:0] g;
    case (d)
      4'd0: g = 30'b01110_10011_10101_11001_10001_01110;
      4'd1: g = 30'b00100_01100_00100_00100_00100_01110;
      4'd2: g = 30'b01110_10001_00010_00100_01000_11111;
      4'd3: g = 30'b11110_00001_00110_00001_00001_11110;
      4'd4: g = 30'b00010_00110_01010_10010_11111_00010;
      4'd5: g = 30'b11111_10000_11110_00001_00001_11110;
      4'd6: g = 30'b01110_10000_11110_10001_10001_01110;
      4'd7: g = 30'b11111_00001_00010_00100_01000_01000;
      4'd8: g = 30'b01110_10001_01110_10001_10001_01110;
      4'd9: g = 30'b01110_10001_01111_00001_00001_01110;
      default: return 5'b11111;
    endcase
    if (r > 3'd5) return 5'b00000;
    return g[29 - 5*int'(r) -: 5];
  endfunction

  assign glyph_code = rom_fn(digit_sel, row_sel);

  // reference model state
  logic [3:0] m_digit, m_pend;
  bit         m_pending;
  int         m_cnt;
  logic [7:0] p_rgb = 8'h00;
  logic       p_hs = 1'b1, p_vs = 1'b1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e_rgb;
    logic       e_hs, e_vs;
    int         e_row, px, py, c;
    bit         ib, bt, blank;
    logic [4:0] code;
    px = int'(pix_x);
    py = int'(pix_y);
    e_row = 0;
    if (reset) begin
      m_digit = 4'hF; m_pend = 4'h0; m_pending = 0; m_cnt = 0;
      e_rgb = 8'h00; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      if (frame_start) begin
        if (digit_load)     m_digit = digit_in;
        else if (m_pending) m_digit = m_pend;
        m_pending = 0;
        m_cnt = (m_cnt + 1) % 32;
      end else if (digit_load) begin
        m_pend = digit_in;
        m_pending = 1;
      end
      ib = video_on && px >= 320 && px < 360 && py >= 240 && py < 304;
      c = 0;
      if (ib) begin
        e_row = (py - 240) / 8;
        c = (px - 320) / 8;
      end
      code = rom_fn(m_digit, 3'(e_row));
      bt = ib && code[4 - c];
      blank = 0;
`ifdef DIGIT_BLINK_EN
      blank = blink && m_cnt >= 16;
`endif
      e_rgb = (bt && m_digit <= 4'd9 && !blank) ? FG_C : (video_on ? BG_C : 8'h00);
      e_hs = hsync_in;
      e_vs = vsync_in;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      p_rgb = e_rgb; p_hs = e_hs; p_vs = e_vs;
    end
    chk("rgb_out", int'(rgb_out), int'(p_rgb));
    chk("hsync_out", int'(hsync_out), int'(p_hs));
    chk("vsync_out", int'(vsync_out), int'(p_vs));
    chk("row_sel", int'(row_sel), e_row);
    chk("digit_sel", int'(digit_sel), int'(m_digit));
    chk("pending", int'(pending), int'(m_pending));
    p_rgb = e_rgb; p_hs = e_hs; p_vs = e_vs;
  endtask

  task automatic set_pix(input int x, input int y, input logic vo);
    pix_x = 10'(x); pix_y = 10'(y); video_on = vo;
  endtask

  typedef struct {
    int         x, y;
    logic       vo, hs, vs;
    logic [7:0] exp_rgb;
  } vec_t;

  vec_t tbl[64];
  int   n = 0;

  task automatic add(input int x, input int y, input logic vo, input logic hs,
                     input logic vs, input logic [7:0] e);
    tbl[n].x = x; tbl[n].y = y; tbl[n].vo = vo;
    tbl[n].hs = hs; tbl[n].vs = vs; tbl[n].exp_rgb = e;
    n++;
  endtask

  initial begin
    reset = 1'b1; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    frame_start = 1'b0; digit_load = 1'b0; blink = 1'b0; digit_in = 4'h0;
    pix_x = '0; pix_y = '0;
    m_digit = 4'hF; m_pend = 4'h0; m_pending = 0; m_cnt = 0;

    // reset
    step(); step();
    reset = 1'b0;
    chk("rst_digit_sel", int'(digit_sel), 15);
    chk("rst_pending", int'(pending), 0);
    chk("rst_rgb", int'(rgb_out), 0);
    chk("rst_hsync", int'(hsync_out), 1);

    // load 6 then frame start
    digit_in = 4'd6; digit_load = 1'b1; step(); digit_load = 1'b0;
    chk("load6_pending", int'(pending), 1);
    chk("load6_sel_hold", int'(digit_sel), 15);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("fs_pending", int'(pending), 0);
    chk("fs_digit_sel", int'(digit_sel), 6);

    // table: row 0 of "6" is 01110, edges, video_on, sync alignment
    add(319, 240, 1, 1, 1, BG_C);
    for (int k = 0; k < 40; k++)
      add(320 + k, 240, 1, 1, 1, (k >= 8 && k < 32) ? FG_C : BG_C);
    add(360, 240, 1, 1, 1, BG_C);
    add(336, 240, 0, 1, 1, 8'h00);
    add(336, 240, 1, 0, 1, FG_C);
    add(336, 240, 1, 0, 1, FG_C);
    add(336, 240, 1, 0, 1, FG_C);
    add(336, 240, 1, 1, 1, FG_C);
    add(320, 248, 1, 1, 1, FG_C);
    add(336, 288, 1, 1, 1, BG_C);
    add(336, 303, 1, 1, 1, BG_C);
    add(336, 304, 1, 1, 1, BG_C);
    add(336, 239, 1, 1, 1, BG_C);
    add(352, 256, 1, 1, 0, BG_C);
    add(320, 256, 0, 1, 0, 8'h00);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        set_pix(tbl[i].x, tbl[i].y, tbl[i].vo);
        hsync_in = tbl[i].hs; vsync_in = tbl[i].vs;
      end else begin
        set_pix(0, 0, 1'b0); hsync_in = 1'b1; vsync_in = 1'b1;
      end
      step();
      if (i >= 1) begin
        chk("tbl_rgb", int'(rgb_out), int'(tbl[i-1].exp_rgb));
        chk("tbl_hsync", int'(hsync_out), int'(tbl[i-1].hs));
        chk("tbl_vsync", int'(vsync_out), int'(tbl[i-1].vs));
      end
    end

    // two loads mid-frame: last one wins at frame start
    digit_in = 4'd3; digit_load = 1'b1; step(); digit_load = 1'b0;
    step();
    digit_in = 4'd8; digit_load = 1'b1; step(); digit_load = 1'b0;
    step(); step();
    chk("mid_sel_hold", int'(digit_sel), 6);
    chk("mid_pending", int'(pending), 1);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("mid_sel_commit", int'(digit_sel), 8);

    // load 12 together with frame start: immediate commit, box blank
    digit_in = 4'd12; digit_load = 1'b1; frame_start = 1'b1; step();
    digit_load = 1'b0; frame_start = 1'b0;
    chk("blank_sel", int'(digit_sel), 12);
    chk("blank_pending", int'(pending), 0);
    for (int y = 240; y < 304; y += 8)
      for (int x = 320; x < 360; x += 4) begin
        set_pix(x, y, 1'b1); step();
      end
    set_pix(336, 240, 1'b1); step(); step();
    chk("blank_rgb", int'(rgb_out), int'(BG_C));

    // reset mid-frame discards the pending digit
    digit_in = 4'd5; digit_load = 1'b1; step(); digit_load = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_mid_pending", int'(pending), 0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("rst_mid_sel", int'(digit_sel), 15);

    // blink across 40 frames
    digit_in = 4'd8; digit_load = 1'b1; frame_start = 1'b1; step();
    digit_load = 1'b0; frame_start = 1'b0;
    blink = 1'b1;
    for (int f = 0; f < 40; f++) begin
      set_pix(336, 240, 1'b1);
      frame_start = 1'b1; step(); frame_start = 1'b0;
      step(); step();
    end
    blink = 1'b0;

    // randomized traffic around the box
    for (int i = 0; i < 4000; i++) begin
      set_pix(300 + int'($urandom_range(0, 79)), 230 + int'($urandom_range(0, 89)),
              ($urandom_range(0, 7) != 0));
      hsync_in    = ($urandom_range(0, 3) != 0);
      vsync_in    = ($urandom_range(0, 5) != 0);
      frame_start = ($urandom_range(0, 19) == 0);
      digit_load  = ($urandom_range(0, 9) == 0);
      digit_in    = 4'($urandom_range(0, 15));
      blink       = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; frame_start = 1'b0; digit_load = 1'b0;
    set_pix(0, 0, 1'b0); hsync_in = 1'b1; vsync_in = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
